// File: rtl/mem_arbiter.sv
// mem_arbiter: two-slot IF/LS byte-serial memory arbiter; define LS_PRIORITY_EN for fixed LS priority instead of round-robin
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        IFreqEn,
  input  logic [31:0] IFaddr,
  output logic        IFfree,
  output logic        instOutEn,
  output logic [31:0] inst,
  input  logic        LSreqEn,
  input  logic        LSRW,
  input  logic [31:0] LSaddr,
  input  logic [1:0]  LSlen,
  input  logic [31:0] Sdata,
  output logic        LSfree,
  output logic        LOutEn,
  output logic [31:0] Ldata,
  output logic        SOutEn,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LR, BUSY_LW} state_t;
  state_t      state;
  logic        if_valid, ls_valid, ls_rw, last_ls, if_ok, pick_ls;
  logic [31:0] if_addr, ls_addr, ls_data, addr, acc, acc_nx;
  logic [1:0]  ls_len, idx;
  logic [2:0]  cnt, n;
  logic [7:0]  wbyte;

  assign IFfree = !if_valid;
  assign LSfree = !ls_valid;

  // transfer length/address of the active requester, grant choice and next assembled word
  always_comb begin
    n = state == BUSY_IF ? 3'd4 : ls_len == 2'd0 ? 3'd1 : ls_len == 2'd1 ? 3'd2 : 3'd4;
    addr = state == BUSY_IF ? if_addr : ls_addr;
    if_ok = if_valid && !clear;
`ifdef LS_PRIORITY_EN
    pick_ls = ls_valid;
`else
    pick_ls = ls_valid && (!if_ok || !last_ls);
`endif
    wbyte = 8'(ls_data >> {cnt[1:0], 3'b000});
    idx = 2'(cnt - 3'd2);
    acc_nx = acc;
    acc_nx[{idx, 3'b000} +: 8] = mem_din;
  end

  // slot capture, arbitration and byte sequencing; cnt equals cycles elapsed since grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      last_ls   <= 1'b0;
      cnt       <= 3'd0;
      acc       <= 32'd0;
      inst      <= 32'd0;
      Ldata     <= 32'd0;
      instOutEn <= 1'b0;
      LOutEn    <= 1'b0;
      SOutEn    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_a     <= 32'd0;
      mem_dout  <= 8'd0;
    end else begin
      instOutEn <= 1'b0;
      LOutEn    <= 1'b0;
      SOutEn    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_a     <= 32'd0;
      mem_dout  <= 8'd0;
      if (IFreqEn && !if_valid && !clear) begin
        if_valid <= 1'b1;
        if_addr  <= IFaddr;
      end
      if (LSreqEn && !ls_valid) begin
        ls_valid <= 1'b1;
        ls_rw    <= LSRW;
        ls_addr  <= LSaddr;
        ls_len   <= LSlen;
        ls_data  <= Sdata;
      end
      if (clear) if_valid <= 1'b0;
      if (state == IDLE) begin
        if (ls_valid || if_ok) begin
          state    <= pick_ls ? (ls_rw ? BUSY_LW : BUSY_LR) : BUSY_IF;
          last_ls  <= pick_ls;
          cnt      <= 3'd1;
          acc      <= 32'd0;
          mem_a    <= pick_ls ? ls_addr : if_addr;
          mem_wr   <= pick_ls && ls_rw;
          mem_dout <= pick_ls && ls_rw ? ls_data[7:0] : 8'd0;
        end
      end else if (state == BUSY_IF && clear) begin
        state <= IDLE;
      end else if (state == BUSY_LW && cnt == n) begin
        SOutEn   <= 1'b1;
        ls_valid <= 1'b0;
        state    <= IDLE;
      end else if (state != BUSY_LW && cnt == n + 3'd1) begin
        state <= IDLE;
        if (state == BUSY_IF) begin
          instOutEn <= 1'b1;
          inst      <= acc_nx;
          if_valid  <= 1'b0;
        end else begin
          LOutEn   <= 1'b1;
          Ldata    <= acc_nx;
          ls_valid <= 1'b0;
        end
      end else begin
        cnt <= cnt + 3'd1;
        if (cnt >= 3'd2) acc <= acc_nx;
        if (cnt < n) begin
          mem_a    <= addr + 32'(cnt);
          mem_wr   <= state == BUSY_LW;
          mem_dout <= state == BUSY_LW ? wbyte : 8'd0;
        end
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: clear  in  1  pipeline flush, cancels instruction fetch.
REQ-003 SHALL have IF ports: IFreqEn in 1 fetch-request pulse; IFaddr in 32; IFfree out 1 fetch slot empty; instOutEn out 1 fetch-done pulse; inst out 32.
REQ-004 SHALL have LS ports: LSreqEn in 1 request pulse; LSRW in 1 (1=store); LSaddr in 32; LSlen in 2; Sdata in 32; LSfree out 1 LS slot empty; LOutEn out 1 load-done pulse; Ldata out 32; SOutEn out 1 store-done pulse.
REQ-005 SHALL have memory ports: mem_din in 8 read byte; mem_dout out 8 write byte; mem_a out 32 byte address; mem_wr out 1 write strobe.

Function
REQ-006 SHALL hold one pending slot per requester; a slot captures its request at the edge on which xReqEn=1 and xfree=1; xReqEn while xfree=0 SHALL be ignored.
REQ-007 SHALL have states IDLE, BUSY_IF, BUSY_LR (load), BUSY_LW (store).
REQ-008 SHALL grant at any edge where state=IDLE and at least one slot is full; a slot captured at edge E is grantable no earlier than edge E+1.
REQ-009 SHALL arbitrate IDLE conflicts round-robin: grant the requester not granted last; the pointer after reset favours LS.
REQ-010 SHALL set transfer length N: IF = 4; LSlen 0 -> 1, 1 -> 2, 2 or 3 -> 4 bytes.
REQ-011 SHALL, counting cycle 1 as the cycle after grant edge G, drive mem_a = addr+k (32-bit wrap-around) in cycle k+1, for k = 0..N-1.
REQ-012 SHALL, for reads, keep mem_wr=0, sample mem_din in cycle k+2 as byte k (little-endian), and assert done with the assembled data in cycle N+2.
REQ-013 SHALL zero-extend load data to 32 bits; sign extension is not this block's job.
REQ-014 SHALL, for stores, drive mem_wr=1 and mem_dout = Sdata byte k in cycle k+1, and assert SOutEn in cycle N+1.
REQ-015 SHALL drive mem_wr=0, mem_a=0 and mem_dout=0 in every cycle with no active byte.
REQ-016 SHALL make each done signal (instOutEn/LOutEn/SOutEn) a one-cycle pulse.
REQ-017 SHALL hold inst/Ldata stable until the next done pulse of the same requester.
REQ-018 SHALL, in the done cycle, be IDLE with the served slot empty, so the matching free output is high; a new request pulsed in that cycle is grantable at the following edge.
REQ-019 SHALL, on an edge with clear=1: empty the IF slot; abort any BUSY_IF transfer (state IDLE next cycle, instOutEn never asserted for it); drop a coincident IFreqEn; leave LS slot and LS transfers untouched.
REQ-020 SHALL never interrupt an LS transfer, including stores, once granted.

Reset
REQ-021 SHALL, at an edge with rst=1: enter IDLE, empty both slots, clear the byte counter and point round-robin at LS.
REQ-022 SHALL, in the cycle after reset: IFfree=1, LSfree=1, all done pulses 0, inst=0, Ldata=0, mem_wr=0, mem_a=0, mem_dout=0.
REQ-023 SHALL treat reset mid-transfer as an abort: no done pulse and no further mem_wr for that transfer.
REQ-024 SHALL give rst priority over clear and over all request inputs.

Configuration
REQ-025 SHALL support macro LS_PRIORITY_EN: when defined, LS wins every IDLE conflict (fixed priority); when undefined, REQ-009 round-robin applies; all timing otherwise identical.

Verification
REQ-026 IF fetch: IFaddr=0x100 pulsed, mem bytes 0x13,0x05,0x10,0x00 -> mem_a 0x100..0x103 in cycles 1-4, instOutEn cycle 6, inst=0x00100513.
REQ-027 Store: LSRW=1, LSlen=1, LSaddr=0xFFFFFFFF, Sdata=0xBEEF -> mem_wr cycles 1-2, mem_a 0xFFFFFFFF then 0x00000000, mem_dout 0xEF then 0xBE, SOutEn cycle 3.
REQ-028 Conflict: IF and LS load pulsed on the same edge after reset -> LS granted first, IF granted at the edge after LOutEn, then LS again on the next conflict; with LS_PRIORITY_EN, LS wins every time.
REQ-029 Flush: clear=1 in cycle 3 of an IF fetch -> no instOutEn, IFfree=1, pending LS load granted next edge with correct Ldata.
REQ-030 Reset in cycle 2 of a 4-byte store -> mem_wr=0 from the next cycle, no SOutEn, both free outputs 1.
